// File: rtl/main_memory_pkg.sv
// Shared cache package: block geometry, main-memory FSM state type and
// address alignment helper used by main_memory.
package main_memory_pkg;

  localparam int CACHE_BLOCK_SIZE  = 128;
  localparam int BLOCK_OFFSET_BITS = 2;
  localparam int BYTE_OFFSET_BITS  = BLOCK_OFFSET_BITS + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // True when a byte address does not point at the start of a block.
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return |addr[BYTE_OFFSET_BITS-1:0];
  endfunction

endpackage

// File: rtl/main_memory.sv
// Fixed-latency block backing store: one outstanding fill, writebacks any cycle.
// Optional sticky protocol-error flag err_o when MAIN_MEM_ERR_CHECK_EN is defined.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int MEM_BLOCKS  = 256,
  parameter int MEM_LATENCY = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mem_req_vld_i,
  input  logic [31:0]                 mem_req_addr_i,
  output logic                        mem_req_rdy_o,
  output logic                        mem_resp_vld_o,
  output logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_o,
  input  logic                        mem_wb_vld_i,
  input  logic [31:0]                 mem_wb_addr_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] mem_wb_data_i
`ifdef MAIN_MEM_ERR_CHECK_EN
  ,
  output logic                        err_o
`endif
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int LSB   = BYTE_OFFSET_BITS;

  logic [CACHE_BLOCK_SIZE-1:0] mem_r [MEM_BLOCKS];

  mem_state_t                  state_r;
  logic [3:0]                  cnt_r;
  logic [IDX_W-1:0]            idx_r;
  logic                        rdy_r;
  logic                        vld_r;
  logic [CACHE_BLOCK_SIZE-1:0] data_r;

  logic [IDX_W-1:0]            req_idx_s;
  logic [IDX_W-1:0]            wb_idx_s;
  logic [IDX_W-1:0]            rd_idx_s;
  logic [CACHE_BLOCK_SIZE-1:0] rd_data_s;
  logic                        unused_s;

  // Upper address bits alias onto the same blocks.
  assign req_idx_s = mem_req_addr_i[LSB +: IDX_W];
  assign wb_idx_s  = mem_wb_addr_i[LSB +: IDX_W];
  assign unused_s  = ^{mem_req_addr_i[31:LSB+IDX_W], mem_req_addr_i[LSB-1:0],
                       mem_wb_addr_i[31:LSB+IDX_W], mem_wb_addr_i[LSB-1:0]};

  assign mem_req_rdy_o   = rdy_r;
  assign mem_resp_vld_o  = vld_r;
  assign mem_resp_data_o = data_r;

  // Read capture with same-cycle writeback forwarding.
  always_comb begin
    rd_idx_s  = idx_r;
    rd_data_s = '0;
    if (state_r == IDLE) begin
      rd_idx_s = req_idx_s;
    end else begin
      rd_idx_s = idx_r;
    end
    if (mem_wb_vld_i && (wb_idx_s == rd_idx_s)) begin
      rd_data_s = mem_wb_data_i;
    end else begin
      rd_data_s = mem_r[rd_idx_s];
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_wb_vld_i) begin
      mem_r[wb_idx_s] <= mem_wb_data_i;
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      rdy_r   <= 1'b1;
      vld_r   <= 1'b0;
      data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          vld_r  <= 1'b0;
          data_r <= '0;
          if (mem_req_vld_i) begin
            idx_r <= req_idx_s;
            cnt_r <= 4'(MEM_LATENCY - 1);
            rdy_r <= 1'b0;
            if (MEM_LATENCY == 1) begin
              state_r <= RESP;
              vld_r   <= 1'b1;
              data_r  <= rd_data_s;
            end else begin
              state_r <= WAIT;
            end
          end else begin
            rdy_r <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd1) begin
            state_r <= RESP;
            vld_r   <= 1'b1;
            data_r  <= rd_data_s;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          rdy_r   <= 1'b1;
          vld_r   <= 1'b0;
          data_r  <= '0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          rdy_r   <= 1'b1;
          vld_r   <= 1'b0;
          data_r  <= '0;
        end
      endcase
    end
  end

`ifdef MAIN_MEM_ERR_CHECK_EN
  logic err_s;
  logic err_r;

  assign err_o = err_r;

  // Protocol violations: request while busy, or misaligned block address.
  always_comb begin
    err_s = 1'b0;
    if (mem_req_vld_i && ((state_r != IDLE) || addr_misaligned(mem_req_addr_i))) begin
      err_s = 1'b1;
    end else if (mem_wb_vld_i && addr_misaligned(mem_wb_addr_i)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`endif

endmodule
